flag_stack: RTL and testbench

Registered condition-flag unit directly downstream of the 8-bit ALU. It captures the ALU's combinational `zero` and `carry` outputs into the architectural Z/C flags when the decoder asserts a flag write. On `call` it saves Z/C onto a small LIFO, and on `ret` it restores them from the LIFO. Its outputs feed the branch/jump condition logic.

---
 rtl/flag_stack.sv | 126 ++++++++++++
 tb/tb_flag_stack.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/flag_stack.sv
// Registered Z/C condition flags with a small LIFO that saves them on call
// and restores them on ret, plus sticky overflow/underflow indicators.
module flag_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zero_in,
  input  logic             carry_in,
  input  logic             flag_we,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  output logic             zero,
  output logic             carry,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic [PTR_W:0]   sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [1:0]       mem [DEPTH];

  logic             empty_w;
  logic             full_w;
  logic             push_ok;
  logic             pop_ok;
  logic             ovf_evt;
  logic             unf_evt;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;
  logic [1:0]       top_entry;

  assign empty_w = (sp_q == '0);
  assign full_w  = (sp_q == FULL_CNT);

  // push/pop are level-sampled every edge with no ready/stall: a cycle with
  // push (or pop) high is one operation. Both high together cancel out.
  assign push_ok = push && !pop && !full_w;
  assign pop_ok  = pop && !push && !empty_w;
  assign ovf_evt = push && !pop && full_w;
  assign unf_evt = pop && !push && empty_w;

  assign wr_idx    = sp_q[PTR_W-1:0];
  assign top_idx   = PTR_W'(sp_q - 1'b1);
  assign top_entry = mem[top_idx];

  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    sp_d    = sp_q;
    if (push && pop) begin
      zero_d  = zero_q;
      carry_d = carry_q;
    end else if (pop_ok) begin
      // A restore takes precedence over any concurrent ALU capture.
      zero_d  = top_entry[1];
      carry_d = top_entry[0];
      sp_d    = sp_q - 1'b1;
    end else begin
      if (push_ok) begin
        sp_d = sp_q + 1'b1;
      end
      if (flag_we) begin
        zero_d  = zero_in;
        carry_d = carry_in;
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end
    if (unf_evt) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; entries at or above sp are meaningless.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_idx] <= {zero_q, carry_q};
    end
  end

  assign zero      = zero_q;
  assign carry     = carry_q;
  assign count     = sp_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_flag_stack.sv
// Directed bench for flag_stack: a vector table for the single-cycle rules
// plus hand-written sequences for reset, fill/drain and error boundaries.
module tb_flag_stack;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic           clk;
  logic           rst;
  logic           zero_in, carry_in, flag_we, push, pop, clr_err;
  logic           zero, carry, empty, full, overflow, underflow;
  logic [PTR_W:0] count;

  int checks;
  int errors;

  logic [1:0] exp_q[$];

  typedef struct {
    logic       we;
    logic       zi;
    logic       ci;
    logic       pu;
    logic       po;
    logic       clr;
    logic       ez;
    logic       ec;
    logic [3:0] ecnt;
    logic       eunf;
  } vec_t;

  vec_t vecs[19];

  flag_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .zero_in   (zero_in),
    .carry_in  (carry_in),
    .flag_we   (flag_we),
    .push      (push),
    .pop       (pop),
    .clr_err   (clr_err),
    .zero      (zero),
    .carry     (carry),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic zi, input logic ci,
                       input logic pu, input logic po, input logic clr);
    @(negedge clk);
    flag_we  = we;
    zero_in  = zi;
    carry_in = ci;
    push     = pu;
    pop      = po;
    clr_err  = clr;
    @(posedge clk);
    #1;
    flag_we = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("reset_immediate",
          {6'd0, zero, carry, count, empty, full, overflow, underflow},
          {6'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [1:0] v;
  logic [1:0] held;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    zero_in  = 1'b0;
    carry_in = 1'b0;
    flag_we  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    clr_err  = 1'b0;
    //              we zi ci pu po clr  ez ec cnt unf
    vecs[0]  = '{1, 1, 0, 0, 0, 0,  1, 0, 4'd0, 0};
    vecs[1]  = '{0, 0, 1, 0, 0, 0,  1, 0, 4'd0, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 0,  1, 0, 4'd1, 0};
    vecs[3]  = '{1, 0, 1, 0, 0, 0,  0, 1, 4'd1, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 0,  0, 1, 4'd2, 0};
    vecs[5]  = '{1, 1, 1, 1, 1, 0,  0, 1, 4'd2, 0};
    vecs[6]  = '{1, 1, 1, 0, 0, 0,  1, 1, 4'd2, 0};
    vecs[7]  = '{0, 0, 0, 1, 0, 0,  1, 1, 4'd3, 0};
    vecs[8]  = '{1, 0, 0, 0, 0, 0,  0, 0, 4'd3, 0};
    vecs[9]  = '{1, 0, 1, 0, 1, 0,  1, 1, 4'd2, 0};
    vecs[10] = '{0, 0, 0, 0, 1, 0,  0, 1, 4'd1, 0};
    vecs[11] = '{0, 0, 0, 0, 1, 0,  1, 0, 4'd0, 0};
    vecs[12] = '{0, 0, 0, 0, 1, 0,  1, 0, 4'd0, 1};
    vecs[13] = '{1, 0, 1, 0, 1, 0,  0, 1, 4'd0, 1};
    vecs[14] = '{0, 0, 0, 0, 1, 1,  0, 1, 4'd0, 1};
    vecs[15] = '{0, 0, 0, 0, 0, 1,  0, 1, 4'd0, 0};
    vecs[16] = '{1, 1, 1, 0, 0, 0,  1, 1, 4'd0, 0};
    vecs[17] = '{1, 0, 0, 1, 0, 0,  0, 0, 4'd1, 0};
    vecs[18] = '{1, 0, 0, 0, 1, 0,  1, 1, 4'd0, 0};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset asserted mid-cycle, then idle with flag_we low.
    reset_mid_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 0, 0);
    end
    check("idle_hold", {14'd0, zero, carry}, 16'd0);

    // Vector table.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].we, vecs[i].zi, vecs[i].ci, vecs[i].pu, vecs[i].po, vecs[i].clr);
      check($sformatf("vec%0d", i),
            {6'd0, zero, carry, count, empty, full, overflow, underflow},
            {6'd0, vecs[i].ez, vecs[i].ec, vecs[i].ecnt,
             vecs[i].ecnt == 4'd0, vecs[i].ecnt == 4'd8, 1'b0, vecs[i].eunf});
    end

    // Fill to DEPTH with random flag values, tracking saved pairs.
    for (int i = 0; i < DEPTH; i++) begin
      v = 2'($urandom_range(0, 3));
      drive(1, v[1], v[0], 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      exp_q.push_back(v);
    end
    check("fill_count", {11'd0, count, full}, {11'd0, 4'd8, 1'b1});

    // Overflow: stack unchanged, flag_we still applies.
    drive(1, ~v[1], ~v[0], 1, 0, 0);
    check("overflow_set", {10'd0, overflow, count, zero, carry},
          {10'd0, 1'b1, 4'd8, ~v[1], ~v[0]});

    // Drain; each pop must return the pair saved in LIFO order.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      held = exp_q.pop_back();
      check($sformatf("drain%0d", i), {12'd0, zero, carry, 2'd0}, {12'd0, held, 2'd0});
    end
    check("drain_empty", {11'd0, count, empty}, {11'd0, 4'd0, 1'b1});

    drive(0, 0, 0, 0, 1, 0);
    check("underflow_set", {13'd0, underflow, zero, carry}, {13'd0, 1'b1, held});
    check("errs_sticky", {14'd0, overflow, underflow}, 16'b11);

    drive(0, 0, 0, 0, 0, 1);
    check("clr_err", {14'd0, overflow, underflow}, 16'b00);

    // Reset during a push aborts it and discards saved entries.
    drive(1, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    check("pre_reset_count", {12'd0, count}, 16'd2);
    @(negedge clk);
    push = 1'b1;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_abort",
          {6'd0, zero, carry, count, empty, full, overflow, underflow},
          {6'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    push = 1'b0;
    rst  = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    check("post_reset_pop", {14'd0, underflow, count == 4'd0}, 16'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
